video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised pixel-clock video timing generator for the OV7670 capture/display path. Produces hsync/vsync/data-enable for an arbitrary raster and a frame-buffer read address with integer pixel replication, e.g. a 320x240 buffer shown as 640x480. Sits between the frame buffer's read port and the display output. Address/read-enable lead the sync/enable outputs by one pclk to absorb the buffer's registered read.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal front porch, sync, back porch (pclks)
- V_ACTIVE, 480: visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porches and sync (lines)
- SCALE, 2: replication factor, both axes; H_ACTIVE and V_ACTIVE must be divisible by it
- SYNC_POL, 0: sync active level (0 = active-low)
- ADDR_W, 17: read address width; 2**ADDR_W >= (H_ACTIVE/SCALE)*(V_ACTIVE/SCALE), else elaboration error
- pclk  in  1  pixel clock, sole clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low holds the raster at origin
- rd_en  out  1  frame-buffer read strobe (active pixel next cycle)
- d_r_addr  out  ADDR_W  frame-buffer read address
- hsync  out  1  horizontal sync, SYNC_POL level when active
- vsync  out  1  vertical sync, SYNC_POL level when active
- de  out  1  active video
- frame_start  out  1  one-pclk pulse with the first pixel (h=0, v=0)
- line_start  out  1  one-pclk pulse at h=0 on every line

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, likewise V_TOTAL. h wraps to 0 and v increments; v wraps at V_TOTAL-1 when h wraps.
- Regions: active when h < H_ACTIVE and v < V_ACTIVE. hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC on every line. vsync active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Address: SRC_W = H_ACTIVE/SCALE. d_r_addr = (v/SCALE)*SRC_W + h/SCALE during active region. Implementation is incremental, no multiplier: x sub-counter advances addr every SCALE active pixels; line_base register; at end of an active line, addr returns to line_base unless line sub-counter = SCALE-1, in which case line_base += SRC_W. At v wrap, addr and line_base = 0.
- Outside active region d_r_addr holds its last value; rd_en = 0.
- en low: h, v, sub-counters, addr, line_base forced to 0 next edge; rd_en, de, frame_start, line_start 0; syncs inactive. en high again: raster restarts at origin on the next edge.

## Timing
- Reset (async, immediate): h=v=0, d_r_addr=0, rd_en=0, de=0, frame_start=0, line_start=0, hsync=vsync=~SYNC_POL.
- rd_en/d_r_addr registered from counter state (1 pclk after counter). hsync/vsync/de/frame_start/line_start are the same decode delayed one further register: rd_en at cycle t, matching de at t+1.
- First cycle after reset release with en=1: rd_en=1, d_r_addr=0; next cycle de=1, frame_start=1, line_start=1.
- Frame period exactly H_TOTAL*V_TOTAL pclks; no dropped or doubled cycles at wrap.
- en deasserted mid-line: outputs idle from the following edge; no partial-line completion.

## Structure
- Package video_timing_pkg: timing-set struct typedef (active/fp/sync/bp per axis) and preset constants VGA_640x480 and QVGA_320x240, plus a function computing total and address width.
- One sub-module, video_axis_counter: counter with wrap, terminal-count output and active/sync region decode; instanced for h (enabled every pclk) and v (enabled on h terminal count).

## Test plan
- Small raster H 8/2/3/1, V 4/1/2/1, SCALE=2, en=1 -> frame = 112 pclks; addresses per line 0,0,1,1,2,2,3,3 for lines 0-1 and 4,4,5,5,6,6,7,7 for lines 2-3; de follows each rd_en by exactly 1 cycle.
- Same raster -> hsync active for h=10..12 on every line (3 cycles, delayed 2 from counter); vsync active for full lines 5-6; both inactive=1 when SYNC_POL=0.
- SCALE=1, H 4/1/1/1, V 2/1/1/1 -> addresses 0..7 consecutive, frame_start once per 35 pclks, line_start every 7.
- Assert rst_n low mid-active line -> same-cycle outputs to reset values; after release, d_r_addr=0 and frame_start one cycle after first rd_en.
- Drop en at h=5 of line 2, raise 3 cycles later -> idle outputs from next edge; restart at address 0 with frame_start.
- Default VGA parameters, 2 frames -> 800x525 per frame; last active address 76799, then wrap to 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing types for the video timing generator.
// axis_timing_t  : active / front porch / sync / back porch of one axis
// timing_set_t   : horizontal + vertical axis timing of one raster
// Presets        : VGA_640x480, QVGA_320x240
// Helpers        : axis_total (pclks or lines per axis), cnt_width, addr_width
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } timing_set_t;

  localparam timing_set_t VGA_640x480 = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33}
  };

  localparam timing_set_t QVGA_320x240 = '{
    h: '{320, 8, 48, 24},
    v: '{240, 5, 2, 16}
  };

  // Full period of one axis.
  function automatic int unsigned axis_total(input axis_timing_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Frame-buffer address width for a raster shown with integer replication.
  function automatic int unsigned addr_width(input timing_set_t t, input int unsigned scale);
    return cnt_width((t.h.active / scale) * (t.v.active / scale));
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter with region decode.
// clk, rst_n  : clock, async active-low reset
// i_clr       : synchronous return to 0 (priority over i_inc)
// i_inc       : advance one position
// o_cnt       : current position (registered)
// o_tc_c      : position is TOTAL-1
// o_active_c  : position < ACTIVE
// o_sync_c    : SYNC_START <= position < SYNC_END
module video_axis_counter #(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc_c,
  output logic         o_active_c,
  output logic         o_sync_c
);

  logic [W-1:0] r_cnt;

  // Position register, wraps to 0 after TOTAL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc_c ? '0 : r_cnt + W'(1);
    end
  end

  // Decode in 32 bits so a region end equal to 2**W is not truncated.
  assign o_cnt      = r_cnt;
  assign o_tc_c     = (32'(r_cnt) == TOTAL - 1);
  assign o_active_c = (32'(r_cnt) < ACTIVE);
  assign o_sync_c   = (32'(r_cnt) >= SYNC_START) && (32'(r_cnt) < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator with integer pixel replication.
// pclk, rst_n  : pixel clock, async active-low reset
// en           : run enable; low parks the raster at the origin
// rd_en        : frame-buffer read strobe (pixel shown next cycle)
// d_r_addr     : frame-buffer read address, holds outside active video
// hsync, vsync : syncs, SYNC_POL level while active
// de           : active video, one cycle after rd_en
// frame_start  : pulse with pixel (0,0);  line_start : pulse at h=0
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
  parameter int unsigned H_FP     = VGA_640x480.h.fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
  parameter int unsigned H_BP     = VGA_640x480.h.bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
  parameter int unsigned V_FP     = VGA_640x480.v.fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
  parameter int unsigned V_BP     = VGA_640x480.v.bp,
  parameter int unsigned SCALE    = 2,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] d_r_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              line_start
);

  localparam axis_timing_t H_T     = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
  localparam axis_timing_t V_T     = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
  localparam int unsigned  H_TOTAL = axis_total(H_T);
  localparam int unsigned  V_TOTAL = axis_total(V_T);
  localparam int unsigned  H_W     = cnt_width(H_TOTAL);
  localparam int unsigned  V_W     = cnt_width(V_TOTAL);
  localparam int unsigned  SC_W    = cnt_width(SCALE);
  localparam int unsigned  SRC_W   = H_ACTIVE / SCALE;
  localparam int unsigned  SRC_PIX = SRC_W * (V_ACTIVE / SCALE);

  if (((H_ACTIVE % SCALE) != 0) || ((V_ACTIVE % SCALE) != 0)) begin : g_bad_scale
    $error("video_timing_gen: active size not divisible by SCALE");
  end
  if (64'(SRC_PIX) > (64'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("video_timing_gen: ADDR_W too small for the source frame");
  end

  logic [H_W-1:0]    w_h;
  logic [V_W-1:0]    w_v;
  logic              w_h_tc, w_h_act, w_h_sync;
  logic              w_v_tc, w_v_act, w_v_sync;
  logic              w_act_c, w_line_end_c, w_frame_end_c;
  logic [SC_W-1:0]   r_x_sub, r_y_sub;
  logic [ADDR_W-1:0] r_next_addr, r_line_base;
  logic              r_hs1, r_vs1, r_fs1, r_ls1;

  video_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .W(H_W)
  ) u_h_cnt (
    .clk(pclk), .rst_n(rst_n), .i_clr(!en), .i_inc(1'b1),
    .o_cnt(w_h), .o_tc_c(w_h_tc), .o_active_c(w_h_act), .o_sync_c(w_h_sync)
  );

  video_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .W(V_W)
  ) u_v_cnt (
    .clk(pclk), .rst_n(rst_n), .i_clr(!en), .i_inc(w_h_tc),
    .o_cnt(w_v), .o_tc_c(w_v_tc), .o_active_c(w_v_act), .o_sync_c(w_v_sync)
  );

  assign w_act_c       = w_h_act && w_v_act;
  assign w_line_end_c  = w_act_c && (32'(w_h) == H_ACTIVE - 1);
  assign w_frame_end_c = w_h_tc && w_v_tc;

  // Incremental address: r_next_addr is the address of the current counter
  // position; each source line is replayed SCALE times from r_line_base.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_sub     <= '0;
      r_y_sub     <= '0;
      r_next_addr <= '0;
      r_line_base <= '0;
    end else if (!en || w_frame_end_c) begin
      r_x_sub     <= '0;
      r_y_sub     <= '0;
      r_next_addr <= '0;
      r_line_base <= '0;
    end else if (w_line_end_c) begin
      r_x_sub <= '0;
      if (r_y_sub == SC_W'(SCALE - 1)) begin
        r_y_sub     <= '0;
        r_line_base <= r_line_base + ADDR_W'(SRC_W);
        r_next_addr <= r_line_base + ADDR_W'(SRC_W);
      end else begin
        r_y_sub     <= r_y_sub + SC_W'(1);
        r_next_addr <= r_line_base;
      end
    end else if (w_act_c) begin
      if (r_x_sub == SC_W'(SCALE - 1)) begin
        r_x_sub     <= '0;
        r_next_addr <= r_next_addr + ADDR_W'(1);
      end else begin
        r_x_sub <= r_x_sub + SC_W'(1);
      end
    end
  end

  // First stage: read request plus decode for the display stage.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      d_r_addr <= '0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_fs1    <= 1'b0;
      r_ls1    <= 1'b0;
    end else if (!en) begin
      rd_en    <= 1'b0;
      d_r_addr <= '0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_fs1    <= 1'b0;
      r_ls1    <= 1'b0;
    end else begin
      rd_en <= w_act_c;
      if (w_act_c) begin
        d_r_addr <= r_next_addr;
      end
      r_hs1 <= w_h_sync;
      r_vs1 <= w_v_sync;
      r_fs1 <= (w_h == '0) && (w_v == '0);
      r_ls1 <= (w_h == '0);
    end
  end

  // Second stage: display-side outputs aligned with the buffer's read data.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!en) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      de          <= rd_en;
      hsync       <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      frame_start <= r_fs1;
      line_start  <= r_ls1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: two small rasters (SCALE 2 with
// active-low syncs, SCALE 1 with active-high syncs) share en/rst_n. A model
// predicts every output from the count of enabled edges since the last
// restart; a monitor compares DUT outputs on each falling edge.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int unsigned AW = 6;
  localparam timing_set_t TS0 = '{h: '{8, 2, 3, 1}, v: '{4, 1, 2, 1}};
  localparam timing_set_t TS1 = '{h: '{4, 1, 1, 1}, v: '{2, 1, 1, 1}};
  localparam int unsigned SC0 = 2;
  localparam int unsigned SC1 = 1;
  localparam bit POL0 = 1'b0;
  localparam bit POL1 = 1'b1;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic          ls;
  } exp_t;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    rd_en_w, de_w, hs_w, vs_w, fs_w, ls_w;
  logic [AW-1:0] addr0, addr1;

  exp_t q0[$];
  exp_t q1[$];
  int unsigned n_en = 0;
  logic [AW-1:0] held0 = '0;
  logic [AW-1:0] held1 = '0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  video_timing_gen #(
    .H_ACTIVE(TS0.h.active), .H_FP(TS0.h.fp), .H_SYNC(TS0.h.sync), .H_BP(TS0.h.bp),
    .V_ACTIVE(TS0.v.active), .V_FP(TS0.v.fp), .V_SYNC(TS0.v.sync), .V_BP(TS0.v.bp),
    .SCALE(SC0), .SYNC_POL(POL0), .ADDR_W(AW)
  ) u_dut0 (
    .pclk(pclk), .rst_n(rst_n), .en(en), .rd_en(rd_en_w[0]), .d_r_addr(addr0),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]),
    .frame_start(fs_w[0]), .line_start(ls_w[0])
  );

  video_timing_gen #(
    .H_ACTIVE(TS1.h.active), .H_FP(TS1.h.fp), .H_SYNC(TS1.h.sync), .H_BP(TS1.h.bp),
    .V_ACTIVE(TS1.v.active), .V_FP(TS1.v.fp), .V_SYNC(TS1.v.sync), .V_BP(TS1.v.bp),
    .SCALE(SC1), .SYNC_POL(POL1), .ADDR_W(AW)
  ) u_dut1 (
    .pclk(pclk), .rst_n(rst_n), .en(en), .rd_en(rd_en_w[1]), .d_r_addr(addr1),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]),
    .frame_start(fs_w[1]), .line_start(ls_w[1])
  );

  // Expected outputs after n consecutive enabled edges: the read stage shows
  // raster position n-1, the display stage position n-2.
  function automatic exp_t predict(input timing_set_t ts, input int unsigned sc,
                                   input bit pol, input int unsigned n,
                                   input logic [AW-1:0] held);
    int unsigned ht, vt, p, h, v;
    exp_t e;
    ht = axis_total(ts.h);
    vt = axis_total(ts.v);
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    e.addr = held;
    if (n >= 1) begin
      p = (n - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      if (h < ts.h.active && v < ts.v.active) begin
        e.rd_en = 1'b1;
        e.addr = AW'((v / sc) * (ts.h.active / sc) + h / sc);
      end
    end
    if (n >= 2) begin
      p = (n - 2) % (ht * vt);
      h = p % ht;
      v = p / ht;
      e.de = (h < ts.h.active) && (v < ts.v.active);
      if (h >= ts.h.active + ts.h.fp && h < ts.h.active + ts.h.fp + ts.h.sync) e.hs = pol;
      if (v >= ts.v.active + ts.v.fp && v < ts.v.active + ts.v.fp + ts.v.sync) e.vs = pol;
      e.fs = (p == 0);
      e.ls = (h == 0);
    end
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e, input exp_t a);
    n_checks++;
    if (a === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got rd_en=%b addr=%0d de=%b hs=%b vs=%b fs=%b ls=%b expected rd_en=%b addr=%0d de=%b hs=%b vs=%b fs=%b ls=%b",
               name, $time, a.rd_en, a.addr, a.de, a.hs, a.vs, a.fs, a.ls,
               e.rd_en, e.addr, e.de, e.hs, e.vs, e.fs, e.ls);
    end
  endtask

  function automatic exp_t actual(input int id);
    exp_t a;
    a.rd_en = rd_en_w[id];
    a.addr  = (id == 0) ? addr0 : addr1;
    a.de    = de_w[id];
    a.hs    = hs_w[id];
    a.vs    = vs_w[id];
    a.fs    = fs_w[id];
    a.ls    = ls_w[id];
    return a;
  endfunction

  // Reset / idle values, checked directly right after an async reset.
  task automatic check_idle(input string name);
    exp_t e;
    e = '0;
    e.hs = ~POL0;
    e.vs = ~POL0;
    compare({name, "_dut0"}, e, actual(0));
    e.hs = ~POL1;
    e.vs = ~POL1;
    compare({name, "_dut1"}, e, actual(1));
  endtask

  // Reference model: push one expected record per DUT per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      if (rst_n && en) n_en++;
      else n_en = 0;
      if (n_en == 0) begin
        held0 = '0;
        held1 = '0;
      end
      e = predict(TS0, SC0, POL0, n_en, held0);
      held0 = e.addr;
      q0.push_back(e);
      e = predict(TS1, SC1, POL1, n_en, held1);
      held1 = e.addr;
      q1.push_back(e);
    end
  end

  // Monitor: pop and compare on every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty_dut0 t=%0t got empty queue expected a record", $time);
      end else begin
        e = q0.pop_front();
        compare("sb_dut0", e, actual(0));
      end
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty_dut1 t=%0t got empty queue expected a record", $time);
      end else begin
        e = q1.pop_front();
        compare("sb_dut1", e, actual(1));
      end
    end
  end

  // Inputs change 1 ns after a falling edge, after the monitor has sampled.
  task automatic run(input int unsigned n);
    repeat (n) @(negedge pclk);
    #1;
  endtask

  initial begin
    run(3);
    check_idle("reset_hold");
    rst_n = 1'b1;
    en = 1'b1;
    run(3 * 112 + 5);

    // Restart, then drop en at h=5 of line 2 of the SCALE=2 raster.
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(2 * 14 + 5);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(150);

    // Async reset in the middle of an active line.
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(20);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    run(2);
    rst_n = 1'b1;
    run(60);

    // Random run lengths with en drops and reset pulses.
    repeat (25) begin
      en = 1'b1;
      run($urandom_range(1, 200));
      if ($urandom_range(0, 3) == 0) begin
        #($urandom_range(0, 3));
        rst_n = 1'b0;
        #1;
        check_idle("rand_rst");
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end else begin
        en = 1'b0;
        run($urandom_range(1, 4));
      end
    end
    en = 1'b1;
    run(120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
